// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner: key FSM state encodings and
// default debounce sizing.
package input_conditioner_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int unsigned DIGIT_NUM_DEF      = 7;
  localparam int unsigned DEBOUNCE_WIDTH_DEF = 20;
  localparam logic [DEBOUNCE_WIDTH_DEF-1:0] DEBOUNCE_TICKS_DEF = 20'd1_000_000;

endpackage

// File: rtl/key_debouncer.sv
// One push button: 2-flop synchronizer, press/release debounce FSM and the
// registered single-cycle press pulse (gated by the caller's arbitration).
module key_debouncer
  import input_conditioner_pkg::*;
#(
  parameter int unsigned                 DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEF,
  parameter logic [DEBOUNCE_WIDTH-1:0]   DEBOUNCE_TICKS = DEBOUNCE_WIDTH'(DEBOUNCE_TICKS_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  input  logic suppress_i,
  output logic press_c,
  output logic pulse_o
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_TICKS - DEBOUNCE_WIDTH'(1);

  logic                      sync1_q, sync2_q;
  logic [1:0]                state_q, state_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      pulse_q, pulse_d;

  // Synchronizer idles released (high) so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Counter is zero in the stable states, so every WAIT entry starts at 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sync2_q) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          press_c = 1'b1;
        end else begin
          cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
        end
      end
      ST_PRESSED: begin
        if (sync2_q) state_d = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pulse_d = press_c & ~suppress_i;
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces three push buttons into arbitrated single-cycle pulses and the
// slide-switch bank into a stable digit_choice vector.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned                 DIGIT_NUM      = DIGIT_NUM_DEF,
  parameter int unsigned                 DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEF,
  parameter logic [DEBOUNCE_WIDTH-1:0]   DEBOUNCE_TICKS = DEBOUNCE_WIDTH'(DEBOUNCE_TICKS_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_load_n,
  input  logic                 key_change_n,
  input  logic                 key_mode_n,
  input  logic [DIGIT_NUM-1:0] sw_choice,
  output logic [DIGIT_NUM-1:0] digit_choice,
  output logic                 digit_load,
  output logic                 digit_change,
  output logic                 mode_change
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_TICKS - DEBOUNCE_WIDTH'(1);

  logic mode_c, load_c, change_c;

  // Priority mode > load > change; losers are suppressed, never deferred.
  key_debouncer #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key_mode (
    .clk        (clk),
    .rst        (rst),
    .key_n_i    (key_mode_n),
    .suppress_i (1'b0),
    .press_c    (mode_c),
    .pulse_o    (mode_change)
  );

  key_debouncer #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key_load (
    .clk        (clk),
    .rst        (rst),
    .key_n_i    (key_load_n),
    .suppress_i (mode_c),
    .press_c    (load_c),
    .pulse_o    (digit_load)
  );

  key_debouncer #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key_change (
    .clk        (clk),
    .rst        (rst),
    .key_n_i    (key_change_n),
    .suppress_i (mode_c | load_c),
    .press_c    (change_c),
    .pulse_o    (digit_change)
  );

  logic [DIGIT_NUM-1:0]      sw_sync1_q, sw_sync2_q, sw_prev_q;
  logic [DIGIT_NUM-1:0]      digit_q, digit_d;
  logic [DEBOUNCE_WIDTH-1:0] sw_cnt_q, sw_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      sw_prev_q  <= '0;
      sw_cnt_q   <= '0;
      digit_q    <= '0;
    end else begin
      sw_sync1_q <= sw_choice;
      sw_sync2_q <= sw_sync1_q;
      sw_prev_q  <= sw_sync2_q;
      sw_cnt_q   <= sw_cnt_d;
      digit_q    <= digit_d;
    end
  end

  // One shared counter: any change in the vector restarts the stability window.
  always_comb begin
    sw_cnt_d = '0;
    digit_d  = digit_q;
    if ((sw_sync2_q != sw_prev_q) || (sw_sync2_q == digit_q)) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == CNT_LAST) begin
      digit_d = sw_sync2_q;
    end else begin
      sw_cnt_d = sw_cnt_q + DEBOUNCE_WIDTH'(1);
    end
  end

  assign digit_choice = digit_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random bouncing inputs,
// compared every cycle against a run-length behavioural model.
module tb_input_conditioner;

  localparam int N = 7;
  localparam int W = 20;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_load_n = 1'b1, key_change_n = 1'b1, key_mode_n = 1'b1;
  logic [N-1:0] sw_choice = '0;
  logic [N-1:0] digit_choice;
  logic         digit_load, digit_change, mode_change;

  input_conditioner #(.DIGIT_NUM(N), .DEBOUNCE_WIDTH(W), .DEBOUNCE_TICKS(20'(T))) dut (
    .clk          (clk),
    .rst          (rst),
    .key_load_n   (key_load_n),
    .key_change_n (key_change_n),
    .key_mode_n   (key_mode_n),
    .sw_choice    (sw_choice),
    .digit_choice (digit_choice),
    .digit_load   (digit_load),
    .digit_change (digit_change),
    .mode_change  (mode_change)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a level is accepted once the synced input (raw delayed
  // two edges) has disagreed with the stable level for T+1 consecutive edges.
  logic         kd1 [3];
  logic         kd2 [3];
  logic         kstable [3];
  int           krun [3];
  logic [2:0]   cand;
  logic         exp_load = 1'b0, exp_change = 1'b0, exp_mode = 1'b0;
  logic [N-1:0] sd1 = '0, sd2 = '0, sprev = '0, exp_digit = '0;
  int           srun = 0;

  always @(posedge clk) begin
    logic [2:0]   raw;
    logic         used;
    logic [N-1:0] sused;
    raw = {key_mode_n, key_change_n, key_load_n};
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        kd1[i] = 1'b1; kd2[i] = 1'b1; kstable[i] = 1'b1; krun[i] = 0;
      end
      exp_load = 1'b0; exp_change = 1'b0; exp_mode = 1'b0;
      sd1 = '0; sd2 = '0; sprev = '0; exp_digit = '0; srun = 0;
    end else begin
      cand = 3'b000;
      for (int i = 0; i < 3; i++) begin
        used   = kd2[i];
        kd2[i] = kd1[i];
        kd1[i] = raw[i];
        krun[i] = (used != kstable[i]) ? krun[i] + 1 : 0;
        if (krun[i] == T + 1) begin
          kstable[i] = used;
          krun[i]    = 0;
          cand[i]    = ~used;
        end
      end
      exp_mode   = cand[2];
      exp_load   = cand[0] & ~cand[2];
      exp_change = cand[1] & ~cand[0] & ~cand[2];
      sused = sd2; sd2 = sd1; sd1 = sw_choice;
      srun  = (sused == sprev) ? srun + 1 : 1;
      sprev = sused;
      if (srun >= T + 1 && sused != exp_digit) exp_digit = sused;
    end
  end

  int cnt_load, cnt_change, cnt_mode;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_eq("digit_load", 32'(digit_load), 32'(exp_load));
    check_eq("digit_change", 32'(digit_change), 32'(exp_change));
    check_eq("mode_change", 32'(mode_change), 32'(exp_mode));
    check_eq("digit_choice", 32'(digit_choice), 32'(exp_digit));
    check_eq("pulse_onehot", 32'($countones({digit_load, digit_change, mode_change}) <= 1), 32'd1);
    cnt_load   += int'(digit_load);
    cnt_change += int'(digit_change);
    cnt_mode   += int'(mode_change);
  endtask

  task automatic clear_counts();
    cnt_load = 0; cnt_change = 0; cnt_mode = 0;
  endtask

  initial begin
    int first;
    int idx;
    logic [N-1:0] saved;
    clear_counts();

    // Reset state
    repeat (3) step();
    rst = 1'b1;
    repeat (4) step();

    // Clean press: one pulse after edge k+T+2, none on release
    clear_counts(); first = -1;
    key_load_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (digit_load && first < 0) first = i;
    end
    key_load_n = 1'b1;
    repeat (12) step();
    check_eq("clean_latency", 32'(first), 32'(T + 3));
    check_eq("clean_count", 32'(cnt_load), 32'd1);

    // Bounce on change key
    clear_counts(); first = -1;
    key_change_n = 1'b0; repeat (2) step();
    key_change_n = 1'b1; step();
    key_change_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (digit_change && first < 0) first = i;
    end
    key_change_n = 1'b1;
    repeat (12) step();
    check_eq("bounce_latency", 32'(first), 32'(T + 3));
    check_eq("bounce_count", 32'(cnt_change), 32'd1);

    // Simultaneous mode and load
    clear_counts();
    key_mode_n = 1'b0; key_load_n = 1'b0;
    repeat (15) step();
    key_mode_n = 1'b1; key_load_n = 1'b1;
    repeat (12) step();
    check_eq("simul_mode", 32'(cnt_mode), 32'd1);
    check_eq("simul_load", 32'(cnt_load), 32'd0);

    // Switch change accepted after the stability window
    first = -1;
    sw_choice = 7'b0010000;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (digit_choice == 7'b0010000 && first < 0) first = i;
    end
    check_eq("sw_latency", 32'(first), 32'(T + 3));
    check_eq("sw_value", 32'(digit_choice), 32'h10);

    // Two-cycle glitch on bit 6 is ignored
    saved = digit_choice;
    first = 0;
    sw_choice[6] = ~sw_choice[6];
    repeat (2) step();
    sw_choice[6] = ~sw_choice[6];
    for (int i = 0; i < 12; i++) begin
      step();
      if (digit_choice != 7'b0010000) first++;
    end
    check_eq("glitch_changes", 32'(first), 32'd0);
    check_eq("glitch_value", 32'(saved), 32'h10);

    // Reset mid-count abandons the press
    clear_counts();
    key_load_n = 1'b0; repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    check_eq("rst_outputs", 32'({digit_choice, digit_load, digit_change, mode_change}), 32'd0);
    key_load_n = 1'b1; rst = 1'b1;
    repeat (12) step();
    check_eq("rst_mid_count", 32'(cnt_load), 32'd0);

    // Key held across reset release pulses exactly once
    clear_counts(); first = -1;
    key_load_n = 1'b0; rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (digit_load && first < 0) first = i;
    end
    key_load_n = 1'b1;
    repeat (10) step();
    check_eq("held_latency", 32'(first), 32'(T + 3));
    check_eq("held_count", 32'(cnt_load), 32'd1);

    // Random bouncing keys, switch noise and occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) key_load_n   = ~key_load_n;
      if ($urandom_range(0, 5) == 0) key_change_n = ~key_change_n;
      if ($urandom_range(0, 5) == 0) key_mode_n   = ~key_mode_n;
      if ($urandom_range(0, 11) == 0) sw_choice = N'($urandom);
      else if ($urandom_range(0, 7) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        sw_choice[idx] = ~sw_choice[idx];
      end
      if (rst && $urandom_range(0, 299) == 0) rst = 1'b0;
      else if (!rst && $urandom_range(0, 2) == 0) rst = 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
